fetch_aligner: RTL
==================

// Module: fetch_aligner
// PURPOSE
// Parametrised successor fetch stage: streams aligned 64-bit words from imem with up to MAX_OUTST requests
// in flight, buffers them as 16-bit parcels and extracts variable-length (16/32/64-bit) instructions.
// Presents one left-justified instruction per valid/ready handshake to decode; flushes on do_jump.
// PARAMETERS
// ADDR_W    64  address width; jump_pc, imem_addr, inst_pc and inst_next_pc are all this width
// DEPTH      4  parcel buffer capacity in 64-bit words (DEPTH*4 parcels); power of 2, >=2
// MAX_OUTST  2  max accepted-but-unanswered imem requests; >=1, <=DEPTH
// RESET_PC   0  fetch start address after reset; bits [2:0] must be 0
// PORTS
// clk            in   1       clock
// rst_n          in   1       asynchronous, active-low reset
// imem_addr      out  ADDR_W  request address; bits [2:0] always 0
// imem_addr_valid out 1       request valid
// imem_addr_ready in  1       request accepted when valid&ready
// imem_data      in   64      response word; parcel0=[63:48] at lowest address ... parcel3=[15:0]
// imem_data_valid in  1       response strobe; in order, exactly one per accepted request, no backpressure
// inst_valid     out  1       instruction available
// inst_ready     in   1       decode accepts (valid&ready); low = stall
// inst_data      out  64      instruction left-justified, unused low bits zero
// inst_pc        out  ADDR_W  address of inst_data
// inst_next_pc   out  ADDR_W  inst_pc + length in bytes (2/4/8), link/fall-through address
// inst_misalign  out  1       misaligned-jump marker (see CONFIGURATION)
// jump_pc        in   ADDR_W  redirect target
// do_jump        in   1       redirect/flush; highest priority
// BEHAVIOUR
// - Reset: fetch_addr=RESET_PC, buffer empty, inflight=0, drop=0, skip=0; all outputs 0.
// - Length from first parcel bits [15:14]: 0x->1 parcel, 10->2, 11->4.
// - Issue: imem_addr_valid=1 iff !do_jump && inflight<MAX_OUTST && count+4*(inflight+1)<=DEPTH*4
//   (count = parcels buffered). On accept: fetch_addr+=8 (wraps mod 2^ADDR_W), inflight++.
// - Response: inflight--. If drop>0: drop--, word discarded. Else push parcels skip..3, then skip<=0.
//   Credit rule guarantees space; a response never overflows the buffer.
// - Output: inst_valid=1 iff count>=len(head parcel). Incomplete instruction waits for next word.
//   Buffer is registered: a response at cycle n can give inst_valid at n+1 earliest.
// - Pop on inst_valid&inst_ready: remove len parcels; inst_pc<=inst_next_pc. Push and pop same cycle legal.
//   Outputs held stable while inst_valid&!inst_ready.
// - do_jump (cycle n): buffer cleared, no request issued in cycle n, fetch_addr<={jump_pc[ADDR_W-1:3],3'b0},
//   skip<=jump_pc[2:1], inst_pc<=jump_pc with bit0 handled per CONFIGURATION,
//   drop<=inflight minus any response in cycle n (a response in cycle n is itself discarded).
//   inst_valid=0 in cycle n+1; issue may resume at n+1 while drop>0 (responses in order).
// - do_jump overrides simultaneous pop, push and issue. Back-to-back jumps: last one wins.
// - Buffer pointers wrap mod DEPTH*4; count width must hold DEPTH*4.
// - rst_n asserted mid-operation: all state returns to reset values immediately; stale responses after
//   reset release are a system error (memory is reset with the core).
// CONFIGURATION
// FETCH_MISALIGN_TRAP_EN defined: do_jump with jump_pc[0]=1 halts fetch (no requests issued, drop still
//   drains); one entry presented: inst_valid=1, inst_data=0, inst_misalign=1, inst_pc=jump_pc,
//   inst_next_pc=jump_pc; after it is accepted, idle until next do_jump.
// Not defined: jump_pc[0] treated as 0, fetch proceeds normally; inst_misalign tied to 0.
// TESTING
// 1 Reset, RESET_PC=0, mem word@0=64'h1234_8000_0001_C000, word@8=64'hAAAA_BBBB_CCCC_DDDD, ready=1 ->
//   insts: pc0 16b 0x1234, pc2 32b 0x8000_0001, pc6 64b 0xC000_AAAA_BBBB_CCCC, next_pc 2/6/0xE.
// 2 inst_ready=0 for 20 cycles -> at most DEPTH words fetched, outputs stable, no response lost.
// 3 imem latency 5, MAX_OUTST=2 -> never >2 unanswered; do_jump to 0x104 with 2 in flight -> both
//   dropped, first inst_pc=0x104 taken from parcel2 of word@0x100.
// 4 do_jump coinciding with response and with inst handshake -> response discarded, no pop, flush ok.
// 5 64-bit inst at pc 0x1A (spans words 0x18/0x20) -> inst_valid only after second word arrives.
// 6 do_jump to 0x201: with macro -> one inst_misalign=1, inst_pc=0x201, no imem requests; without ->
//   fetch from 0x200, inst_pc=0x200, inst_misalign=0.

Source files
------------

// File: rtl/fetch_aligner_if.sv
// Fetch-stage bus bundle: imem request/response, decode handshake and redirect.
// The master modport is the fetch stage; slave is the memory/decode/redirect side.
interface fetch_aligner_if #(
  parameter int unsigned ADDR_W = 64
);
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_addr_valid;
  logic              imem_addr_ready;
  logic [63:0]       imem_data;
  logic              imem_data_valid;
  logic              inst_valid;
  logic              inst_ready;
  logic [63:0]       inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic [ADDR_W-1:0] inst_next_pc;
  logic              inst_misalign;
  logic [ADDR_W-1:0] jump_pc;
  logic              do_jump;

  modport master (
    output imem_addr, imem_addr_valid, inst_valid, inst_data, inst_pc, inst_next_pc, inst_misalign,
    input  imem_addr_ready, imem_data, imem_data_valid, inst_ready, jump_pc, do_jump
  );

  modport slave (
    input  imem_addr, imem_addr_valid, inst_valid, inst_data, inst_pc, inst_next_pc, inst_misalign,
    output imem_addr_ready, imem_data, imem_data_valid, inst_ready, jump_pc, do_jump
  );
endinterface

// File: rtl/fetch_aligner.sv
// Fetch aligner: streams aligned 64-bit words from imem with bounded outstanding requests,
// buffers 16-bit parcels and presents one left-justified 16/32/64-bit instruction per handshake.
// Optional macro FETCH_MISALIGN_TRAP_EN: an odd jump target halts fetch and presents a single
// misaligned-jump marker entry instead of instructions.
module fetch_aligner #(
  parameter int unsigned       ADDR_W    = 64,
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       MAX_OUTST = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input logic             clk,
  input logic             rst_n,
  fetch_aligner_if.master bus
);
  localparam int unsigned NPAR = DEPTH * 4;
  localparam int unsigned PW   = $clog2(NPAR);
  localparam int unsigned CW   = $clog2(MAX_OUTST + 1);

  logic [15:0]       buf_q [NPAR];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [PW:0]       count_q;
  logic [CW-1:0]     inflight_q, drop_q;
  logic [1:0]        skip_q;
  logic [ADDR_W-1:0] fetch_addr_q, pc_q;
  logic              run_q;
  logic              halt_q, mis_q;
  logic              jump_lsb;

  logic [15:0] p0, p1, p2, p3;
  logic [2:0]  len;
  logic [2:0]  push_n;
  logic        buf_valid, issue_room, accept, resp, push, pop;
  logic [63:0] data_raw;

  assign p0 = buf_q[rd_ptr_q];
  assign p1 = buf_q[rd_ptr_q + PW'(1)];
  assign p2 = buf_q[rd_ptr_q + PW'(2)];
  assign p3 = buf_q[rd_ptr_q + PW'(3)];

  // Length in parcels from the head parcel: 0x -> 1, 10 -> 2, 11 -> 4.
  assign len       = !p0[15] ? 3'd1 : (p0[14] ? 3'd4 : 3'd2);
  assign buf_valid = count_q >= (PW + 1)'(len);
  assign data_raw  = {p0, (len != 3'd1) ? p1 : 16'h0, len[2] ? p2 : 16'h0, len[2] ? p3 : 16'h0};
  assign push_n    = 3'd4 - {1'b0, skip_q};

  // A word may only be requested if its parcels are guaranteed room on arrival.
  assign issue_room = (32'(count_q) + 32'(inflight_q) * 4 + 4) <= NPAR;

  assign bus.imem_addr       = fetch_addr_q;
  assign bus.imem_addr_valid = run_q && !halt_q && !bus.do_jump &&
                               (inflight_q < CW'(MAX_OUTST)) && issue_room;
  assign accept = bus.imem_addr_valid && bus.imem_addr_ready;
  assign resp   = bus.imem_data_valid;
  assign push   = resp && (drop_q == '0) && !bus.do_jump && !halt_q;
  assign pop    = buf_valid && !halt_q && !mis_q && bus.inst_ready && !bus.do_jump;
  assign bus.inst_pc = pc_q;

  // Decode-side outputs; the marker entry takes precedence over buffered parcels.
  always_comb begin
    bus.inst_valid    = 1'b0;
    bus.inst_data     = '0;
    bus.inst_next_pc  = '0;
    bus.inst_misalign = 1'b0;
    if (mis_q) begin
      bus.inst_valid    = 1'b1;
      bus.inst_next_pc  = pc_q;
      bus.inst_misalign = 1'b1;
    end else if (buf_valid && !halt_q) begin
      bus.inst_valid   = 1'b1;
      bus.inst_data    = data_raw;
      bus.inst_next_pc = pc_q + ADDR_W'({len, 1'b0});
    end
  end

  // Parcel storage: write parcels skip..3 of an accepted response at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NPAR); i++) buf_q[i] <= '0;
    end else if (push) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= int'(skip_q)) begin
          buf_q[wr_ptr_q + PW'(i) - PW'(skip_q)] <= bus.imem_data[63-16*i -: 16];
        end
      end
    end
  end

  // Pointers, credits and PC; a jump overrides push, pop and issue in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      inflight_q   <= '0;
      drop_q       <= '0;
      skip_q       <= '0;
      fetch_addr_q <= RESET_PC;
      pc_q         <= RESET_PC;
      run_q        <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (bus.do_jump) begin
        rd_ptr_q     <= '0;
        wr_ptr_q     <= '0;
        count_q      <= '0;
        // Everything still in flight is stale; a response this cycle is already discarded.
        inflight_q   <= inflight_q - CW'(resp);
        drop_q       <= inflight_q - CW'(resp);
        skip_q       <= bus.jump_pc[2:1];
        fetch_addr_q <= {bus.jump_pc[ADDR_W-1:3], 3'b000};
        pc_q         <= {bus.jump_pc[ADDR_W-1:1], jump_lsb};
      end else begin
        if (accept) fetch_addr_q <= fetch_addr_q + ADDR_W'(8);
        inflight_q <= inflight_q + CW'(accept) - CW'(resp);
        if (resp && drop_q != '0) drop_q <= drop_q - CW'(1);
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PW'(push_n);
          skip_q   <= '0;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(len);
          pc_q     <= bus.inst_next_pc;
        end
        count_q <= count_q + (push ? (PW + 1)'(push_n) : '0) - (pop ? (PW + 1)'(len) : '0);
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign jump_lsb = bus.jump_pc[0];

  // Odd jump target: stop fetching and offer one marker entry until the next jump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q <= 1'b0;
      mis_q  <= 1'b0;
    end else if (bus.do_jump) begin
      halt_q <= bus.jump_pc[0];
      mis_q  <= bus.jump_pc[0];
    end else if (mis_q && bus.inst_ready) begin
      mis_q <= 1'b0;
    end
  end
`else
  logic unused_jump_lsb;
  assign unused_jump_lsb = bus.jump_pc[0];
  assign jump_lsb        = 1'b0;
  assign halt_q          = 1'b0;
  assign mis_q           = 1'b0;
`endif
endmodule
